bcd_counter_4d: RTL
===================

Name: bcd_counter_4d

Overview:
- Multi-digit synchronous BCD up/down counter with prescaler, parallel load and clear.
- Produces packed 4-bit BCD digits that drive one decoder_hex_10 instance per display digit.
- Guarantees every digit nibble is always 0..9, so downstream decoder error flags stay low in normal operation.

Parameters:
- DIGITS, 4, number of BCD digits (≥1).
- TICK_DIV, 1, clock cycles per count step (≥1). 1 means count every enabled cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable. Prescaler advances only while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled on the step cycle.
- clr  input  1  synchronous clear to all zeros.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  load value. Nibble 0 (bits 3:0) is the least-significant digit.
- digits  output  4*DIGITS  current count, packed like load_val.
- wrap  output  1  one-cycle pulse: count wrapped 9..9→0..0 (up) or 0..0→9..9 (down).
- load_err  output  1  one-cycle pulse: load rejected because some load_val nibble was >9.

Behaviour:
- Reset (rst_n low, asynchronous): digits=0, wrap=0, load_err=0, prescaler=0. Release is synchronous to the next clk edge. Reset mid-count discards all state.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Priority per edge: clr > load > count step.
- clr=1: digits←0, prescaler←0, wrap←0, load_err←0. Any simultaneous load or step is ignored.
- load=1 (clr=0), all nibbles ≤9: digits←load_val next edge, prescaler←0, wrap←0, load_err←0.
- load=1 (clr=0), any nibble in 10..15: digits unchanged, prescaler unchanged, load_err←1 for exactly one cycle, wrap←0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1 and no clr/load; holds while en=0.
  - step = en & (prescaler==TICK_DIV-1). On step the prescaler returns to 0.
  - With TICK_DIV=1, step=en.
- Step up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple carry, resolved within one cycle).
- Step down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Wrap:
  - All digits 9 stepping up → all 0, with wrap=1 in the cycle the new value is visible.
  - All digits 0 stepping down → all 9, with wrap=1 in the same way.
- wrap and load_err are 0 in every cycle not covered above.
- Latency: one clock from qualifying edge inputs to digits/wrap/load_err.
- up may change on any cycle. Only its value at a step edge matters; there is no hysteresis.
- Invariant: every nibble of digits ∈ 0..9 at all times.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W=4
  - BCD_MAX=4'd9
  - BCD_ZERO=4'd0
  - function is_bcd(nibble), reused by load validation and by testbench checkers.
- Sub-module bcd_digit, generated DIGITS times:
  - Inputs: clk, rst_n, clr, ld, ld_val[3:0], step_in (carry/borrow in), up.
  - Outputs: q[3:0], step_out (asserted when step_in and q==9 up / q==0 down).
  - Chain: step_in of digit i = step_out of digit i-1; digit 0 takes the prescaler step.
- wrap = registered step_out of the top digit.
- Prescaler and load validation stay in the top level.

Test Plan:
- Reset/count (DIGITS=4, TICK_DIV=1): reset low then release, en=1, up=1 for 12 cycles → digits 0x0000,0x0001,…,0x0009,0x0010,0x0011. wrap and load_err stay 0.
- Up wrap: load 0x9998, en=1, up=1 → next cycle 0x9999, then 0x0000 with wrap=1 for one cycle, then 0x0001 with wrap=0.
- Down/borrow and down wrap: load 0x0100, up=0 → 0x0099, 0x0098. Load 0x0000, step down → 0x9999 with wrap=1.
- Invalid load: digits=0x0042, load=1, load_val=0x12A4 → digits stay 0x0042, load_err=1 for one cycle. load_val=0x1234 next → 0x1234, load_err=0.
- Priority and prescaler (TICK_DIV=3): clr and load asserted together → 0x0000. With en=1, steps occur every 3rd cycle. Dropping en for 5 cycles freezes both count and prescaler phase. Load mid-phase restarts the 3-cycle spacing.
- Async reset mid-operation: assert rst_n low between edges while counting at 0x0573 → digits=0x0000 immediately, with no glitch pulses on wrap/load_err. Counting resumes from 0x0001 on the first enabled edge after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-digit counter and its checkers.
package bcd_pkg;

    localparam int              BCD_W    = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter: clear, load, and +/-1 with carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             step_in,
    input  logic             up,
    output logic [BCD_W-1:0] q,
    output logic             step_out
);

    // Carry (up) or borrow (down) ripples combinationally into the next digit.
    assign step_out = step_in & (up ? (q == BCD_MAX) : (q == BCD_ZERO));

    // Digit register: clear beats load beats step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_ZERO;
        end else if (clr) begin
            q <= BCD_ZERO;
        end else if (ld) begin
            q <= ld_val;
        end else if (step_in) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_ZERO : q + 4'd1;
            end else begin
                q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4d.sv
// Multi-digit BCD up/down counter with prescaler, parallel load and clear.
// Digits are packed with nibble 0 as the least-significant digit.
module bcd_counter_4d
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] digits,
    output logic                    wrap,
    output logic                    load_err
);

    // A one-bit prescaler is kept even for TICK_DIV=1; it simply stays at zero.
    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps;
    logic            ld_ok;
    logic            ld_go;
    logic            ld_bad;
    logic            step;
    logic [DIGITS:0] chain;

    // Load is accepted only if every nibble is a legal decimal digit.
    always_comb begin
        ld_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ld_ok = ld_ok & is_bcd(load_val[i*BCD_W +: BCD_W]);
        end
    end

    assign ld_go  = load & ~clr &  ld_ok;
    assign ld_bad = load & ~clr & ~ld_ok;

    // Any clr or load (accepted or rejected) suppresses the count step.
    assign step     = en & ~clr & ~load & (ps == PS_LAST);
    assign chain[0] = step;

    // Prescaler: restarts on clear/accepted load, freezes on rejected load or en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps <= '0;
        end else if (clr || ld_go) begin
            ps <= '0;
        end else if (ld_bad) begin
            ps <= ps;
        end else if (en) begin
            ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gen_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .ld       (ld_go),
                .ld_val   (load_val[g*BCD_W +: BCD_W]),
                .step_in  (chain[g]),
                .up       (up),
                .q        (digits[g*BCD_W +: BCD_W]),
                .step_out (chain[g+1])
            );
        end
    endgenerate

    // Status pulses: carry out of the top digit is a full wrap; bad load flags an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= chain[DIGITS];
            load_err <= ld_bad;
        end
    end

endmodule
